// File: rtl/sfr_bank.sv
// sfr_bank: bank of NREG WIDTH-bit SFRs with byte/bit software access,
// per-bit hardware set/clear, registered read data and illegal-access pulse.
module sfr_bank #(
  parameter int WIDTH = 8,
  parameter int BW = 3,
  parameter int NREG = 4,
  parameter int ABITS = 2,
  parameter logic [NREG*WIDTH-1:0] INITV = '0,
  parameter logic [NREG-1:0] BITMASK = '1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  oe,
  input  logic                  Bb,
  input  logic [ABITS-1:0]      addr,
  input  logic [BW-1:0]         bitsel,
  input  logic [WIDTH-1:0]      din,
  input  logic                  bin,
  input  logic [NREG*WIDTH-1:0] hw_set,
  input  logic [NREG*WIDTH-1:0] hw_clr,
  output logic [NREG*WIDTH-1:0] cout,
  output logic [WIDTH-1:0]      dout,
  output logic                  bout,
  output logic                  rvalid,
  output logic                  err
);
  logic [NREG-1:0][WIDTH-1:0] regs_q, regs_d;
  logic [WIDTH-1:0] dout_q, dout_d, cur, wm, wv, hw;
  logic bout_q, bout_d, rvalid_q, rvalid_d, err_q, err_d;
  logic hit, bm, legal, rd;
  always_comb begin
    cur = '0;
    hit = 1'b0;
    bm = 1'b0;
    hw = '0;
    for (int i = 0; i < NREG; i++)
      if (addr == ABITS'(i)) begin
        cur = regs_q[i];
        hit = 1'b1;
        bm = BITMASK[i];
      end
    legal = hit && (Bb || bm);
    wm = Bb ? '1 : WIDTH'(1) << bitsel;
    wv = Bb ? din : {WIDTH{bin}};
    // software-written bits win; elsewhere hw_set beats hw_clr
    for (int i = 0; i < NREG; i++) begin
      hw = hw_set[i*WIDTH +: WIDTH] | (regs_q[i] & ~hw_clr[i*WIDTH +: WIDTH]);
      regs_d[i] = (en && legal && addr == ABITS'(i)) ? (wv & wm) | (hw & ~wm) : hw;
    end
    rd = oe && !en;
    rvalid_d = rd;
    err_d = (en || oe) && !legal;
    dout_d = !rd ? dout_q : !legal ? '0 : Bb ? cur : dout_q;
    bout_d = !rd ? bout_q : !legal ? 1'b0 : !Bb ? cur[bitsel] : bout_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      regs_q <= INITV;
      dout_q <= '0;
      bout_q <= 1'b0;
      rvalid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      regs_q <= regs_d;
      dout_q <= dout_d;
      bout_q <= bout_d;
      rvalid_q <= rvalid_d;
      err_q <= err_d;
    end
  assign cout = regs_q;
  assign dout = dout_q;
  assign bout = bout_q;
  assign rvalid = rvalid_q;
  assign err = err_q;
endmodule

// File: tb/tb_sfr_bank.sv
// tb_sfr_bank: scoreboard bench for sfr_bank; a 4-register instance for the
// main paths and a 3-register instance with a partial BITMASK for illegal access.
module tb_sfr_bank;
  typedef struct packed {logic [7:0] d; logic b; logic v; logic e;} exp_t;
  logic clk = 0, rst_n = 1;
  logic en = 0, oe = 0, bb = 0, bin = 0;
  logic [1:0] addr = 0;
  logic [2:0] bitsel = 0;
  logic [7:0] din = 0;
  logic [31:0] hw_set = 0, hw_clr = 0, cout;
  logic [7:0] dout;
  logic bout, rvalid, err;
  logic e3 = 0, o3 = 0, bb3 = 0, bin3 = 0;
  logic [1:0] addr3 = 0;
  logic [2:0] bitsel3 = 0;
  logic [7:0] din3 = 0, dout3;
  logic [23:0] cout3;
  logic bout3, rvalid3, err3;
  exp_t q[$];
  exp_t x;
  int tests = 0, fails = 0;

  sfr_bank #(.WIDTH(8), .BW(3), .NREG(4), .ABITS(2), .INITV(32'h0700FF00), .BITMASK(4'b1111)) dut (
    .clk(clk), .reset_n(rst_n), .en(en), .oe(oe), .Bb(bb), .addr(addr), .bitsel(bitsel),
    .din(din), .bin(bin), .hw_set(hw_set), .hw_clr(hw_clr), .cout(cout), .dout(dout),
    .bout(bout), .rvalid(rvalid), .err(err));

  sfr_bank #(.WIDTH(8), .BW(3), .NREG(3), .ABITS(2), .INITV(24'h3C0000), .BITMASK(3'b011)) dut3 (
    .clk(clk), .reset_n(rst_n), .en(e3), .oe(o3), .Bb(bb3), .addr(addr3), .bitsel(bitsel3),
    .din(din3), .bin(bin3), .hw_set(24'h0), .hw_clr(24'h0), .cout(cout3), .dout(dout3),
    .bout(bout3), .rvalid(rvalid3), .err(err3));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e, input logic o, input logic b, input logic [1:0] a,
                     input logic [2:0] s, input logic [7:0] d, input logic bi);
    en = e; oe = o; bb = b; addr = a; bitsel = s; din = d; bin = bi;
  endtask

  task automatic test_reset;
    rst_n = 0;
    #1;
    tests++;
    if (cout !== 32'h0700FF00) begin fails++; $display("FAIL reset_cout got %h want 0700ff00", cout); end
    tests++;
    if ({dout, bout, rvalid, err} !== 11'h0) begin
      fails++; $display("FAIL reset_out got %h/%b/%b/%b want 0/0/0/0", dout, bout, rvalid, err);
    end
    tests++;
    if ({cout3, rvalid3, err3} !== {24'h3C0000, 2'b00}) begin
      fails++; $display("FAIL reset_dut3 got %h/%b/%b want 3c0000/0/0", cout3, rvalid3, err3);
    end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_byte_write_read;
    drv(1, 0, 1, 2, 0, 8'hA5, 0); q.push_back('{8'h00, 0, 0, 0});
    tick; x = q.pop_front(); tests++;
    if ({dout, bout, rvalid, err} !== x) begin fails++; $display("FAIL bw_write got %h want %h", {dout, bout, rvalid, err}, x); end
    tests++;
    if (cout[23:16] !== 8'hA5) begin fails++; $display("FAIL bw_cout got %h want a5", cout[23:16]); end
    drv(0, 1, 1, 2, 0, 0, 0); q.push_back('{8'hA5, 0, 1, 0});
    tick; x = q.pop_front(); tests++;
    if ({dout, bout, rvalid, err} !== x) begin fails++; $display("FAIL bw_read got %h want %h", {dout, bout, rvalid, err}, x); end
    drv(0, 1, 0, 2, 0, 0, 0); q.push_back('{8'hA5, 1, 1, 0});
    tick; x = q.pop_front(); tests++;
    if ({dout, bout, rvalid, err} !== x) begin fails++; $display("FAIL bit_read got %h want %h", {dout, bout, rvalid, err}, x); end
    drv(0, 0, 0, 0, 0, 0, 0); q.push_back('{8'hA5, 1, 0, 0});
    tick; x = q.pop_front(); tests++;
    if ({dout, bout, rvalid, err} !== x) begin fails++; $display("FAIL rd_hold got %h want %h", {dout, bout, rvalid, err}, x); end
  endtask

  task automatic test_bit_vs_hw;
    drv(1, 0, 1, 1, 0, 8'h00, 0);
    tick;
    drv(1, 0, 0, 1, 3, 0, 1);
    hw_clr = 32'h0000_0800; hw_set = 32'h0000_4000;
    tick;
    tests++;
    if (cout[15:8] !== 8'h48) begin fails++; $display("FAIL bit_vs_hw got %h want 48", cout[15:8]); end
    drv(0, 0, 0, 0, 0, 0, 0);
    hw_set = 32'h1000_0000; hw_clr = 32'h1100_0000;
    tick;
    hw_set = 0; hw_clr = 0;
    tests++;
    if (cout[31:24] !== 8'h16) begin fails++; $display("FAIL set_over_clr got %h want 16", cout[31:24]); end
  endtask

  task automatic test_byte_override;
    drv(1, 0, 1, 0, 0, 8'h10, 0); hw_set = 32'h0000_00FF;
    tick;
    tests++;
    if (cout[7:0] !== 8'h10) begin fails++; $display("FAIL byte_override got %h want 10", cout[7:0]); end
    drv(0, 1, 1, 0, 0, 0, 0); hw_set = 32'h0000_0001; q.push_back('{8'h10, 1, 1, 0});
    tick; hw_set = 0; x = q.pop_front(); tests++;
    if ({dout, bout, rvalid, err} !== x) begin fails++; $display("FAIL rd_preset got %h want %h", {dout, bout, rvalid, err}, x); end
    tests++;
    if (cout[7:0] !== 8'h11) begin fails++; $display("FAIL hw_set_after got %h want 11", cout[7:0]); end
  endtask

  task automatic test_collision;
    drv(1, 1, 1, 2, 0, 8'h5E, 0); q.push_back('{8'h10, 1, 0, 0});
    tick; x = q.pop_front(); tests++;
    if ({dout, bout, rvalid, err} !== x) begin fails++; $display("FAIL collision got %h want %h", {dout, bout, rvalid, err}, x); end
    tests++;
    if (cout[23:16] !== 8'h5E) begin fails++; $display("FAIL collision_wr got %h want 5e", cout[23:16]); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] m;
    m = 32'h165E4811;
    for (int i = 0; i < 4; i++) begin
      drv(0, 1, 1, 2'(i), 0, 0, 0); q.push_back('{m[i*8 +: 8], 1, 1, 0});
      tick; x = q.pop_front(); tests++;
      if ({dout, bout, rvalid, err} !== x) begin fails++; $display("FAIL b2b_%0d got %h want %h", i, {dout, bout, rvalid, err}, x); end
    end
    drv(0, 0, 0, 0, 0, 0, 0); q.push_back('{8'h16, 1, 0, 0});
    tick; x = q.pop_front(); tests++;
    if ({dout, bout, rvalid, err} !== x) begin fails++; $display("FAIL b2b_end got %h want %h", {dout, bout, rvalid, err}, x); end
  endtask

  task automatic test_illegal;
    e3 = 1; o3 = 0; bb3 = 0; addr3 = 2; bitsel3 = 0; bin3 = 1; q.push_back('{8'h00, 0, 0, 1});
    tick; x = q.pop_front(); tests++;
    if ({dout3, bout3, rvalid3, err3} !== x) begin fails++; $display("FAIL ill_bitwr got %h want %h", {dout3, bout3, rvalid3, err3}, x); end
    tests++;
    if (cout3 !== 24'h3C0000) begin fails++; $display("FAIL ill_bitwr_cout got %h want 3c0000", cout3); end
    e3 = 0; q.push_back('{8'h00, 0, 0, 0});
    tick; x = q.pop_front(); tests++;
    if ({dout3, bout3, rvalid3, err3} !== x) begin fails++; $display("FAIL err_pulse got %h want %h", {dout3, bout3, rvalid3, err3}, x); end
    o3 = 1; bb3 = 1; q.push_back('{8'h3C, 0, 1, 0});
    tick; x = q.pop_front(); tests++;
    if ({dout3, bout3, rvalid3, err3} !== x) begin fails++; $display("FAIL ok_read3 got %h want %h", {dout3, bout3, rvalid3, err3}, x); end
    addr3 = 3; q.push_back('{8'h00, 0, 1, 1});
    tick; x = q.pop_front(); tests++;
    if ({dout3, bout3, rvalid3, err3} !== x) begin fails++; $display("FAIL ill_read got %h want %h", {dout3, bout3, rvalid3, err3}, x); end
    o3 = 0; e3 = 1; bb3 = 0; addr3 = 0; bitsel3 = 7; q.push_back('{8'h00, 0, 0, 0});
    tick; e3 = 0; x = q.pop_front(); tests++;
    if ({dout3, bout3, rvalid3, err3} !== x) begin fails++; $display("FAIL ok_bitwr3 got %h want %h", {dout3, bout3, rvalid3, err3}, x); end
    tests++;
    if (cout3 !== 24'h3C0080) begin fails++; $display("FAIL ok_bitwr3_cout got %h want 3c0080", cout3); end
  endtask

  task automatic test_reset_mid_read;
    drv(0, 1, 1, 1, 0, 0, 0); q.push_back('{8'h48, 1, 1, 0});
    tick; x = q.pop_front(); tests++;
    if ({dout, bout, rvalid, err} !== x) begin fails++; $display("FAIL pre_rst_read got %h want %h", {dout, bout, rvalid, err}, x); end
    #2 rst_n = 0;
    #1;
    tests++;
    if ({cout, dout, bout, rvalid, err} !== {32'h0700FF00, 11'h0}) begin
      fails++; $display("FAIL mid_rst got %h/%h/%b/%b/%b want 0700ff00/0/0/0/0", cout, dout, bout, rvalid, err);
    end
    drv(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #2;
    test_reset;
    test_byte_write_read;
    test_bit_vs_hw;
    test_byte_override;
    test_collision;
    test_back_to_back;
    test_illegal;
    test_reset_mid_read;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
